// File: rtl/display_mode_ctrl_if.sv
// display_mode_ctrl_if
// Groups the game-event inputs and the object-mux configuration outputs of
// display_mode_ctrl into one bundle.
//   startOfFrame  : one-cycle pulse per VGA frame
//   startGame, pauseKey, collision, gameOver : one-cycle event pulses
//   timeLow       : level, remaining game time below threshold
//   layerEnable   : bit0 smiley, bit1 box, bit2 timer draw gates
//   bgOverride    : mux selects bgOverrideRGB instead of the background
//   bgOverrideRGB : RGB332 override colour
//   gameState     : IDLE=0, PLAY=1, FLASH=2, PAUSE=3, OVER=4
// master = event source / mux consumer side, slave = the sequencer itself.
interface display_mode_ctrl_if;
    logic       startOfFrame;
    logic       startGame;
    logic       pauseKey;
    logic       collision;
    logic       gameOver;
    logic       timeLow;
    logic [2:0] layerEnable;
    logic       bgOverride;
    logic [7:0] bgOverrideRGB;
    logic [2:0] gameState;

    modport master (
        output startOfFrame, startGame, pauseKey, collision, gameOver, timeLow,
        input  layerEnable, bgOverride, bgOverrideRGB, gameState
    );

    modport slave (
        input  startOfFrame, startGame, pauseKey, collision, gameOver, timeLow,
        output layerEnable, bgOverride, bgOverrideRGB, gameState
    );
endinterface

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl
// Frame-synchronous game-display sequencer. Game events are latched during a
// frame and acted on only at the next startOfFrame, so the object mux
// configuration never changes mid-frame (no tearing).
// Ports:
//   clk    : system clock
//   resetN : asynchronous, active-low reset
//   bus    : display_mode_ctrl_if.slave (events in, layer gates/override out)
module display_mode_ctrl #(
    parameter int unsigned BLINK_FRAMES    = 16,
    parameter int unsigned FLASH_FRAMES    = 8,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter logic [7:0]  FLASH_RGB       = 8'hE0,
    parameter logic [7:0]  PAUSE_RGB       = 8'h49,
    parameter logic [7:0]  OVER_RGB        = 8'h03
) (
    input logic               clk,
    input logic               resetN,
    display_mode_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        FLASH = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] OVER_LAST  = 8'(GAMEOVER_FRAMES - 1);

    state_t     state, stateNext;
    logic [3:0] pulses, pending, effective;
    logic [7:0] frameCnt, frameCntNext;
    logic [7:0] blinkCnt, blinkCntNext;
    logic       phase, phaseNext;
    logic [2:0] layerReg, layerNext;
    logic       bgReg, bgNext;
    logic [7:0] rgbReg, rgbNext;

    // Event bits ordered {gameOver, pauseKey, collision, startGame}. A pulse on
    // the startOfFrame cycle itself counts together with anything latched
    // earlier in the frame.
    assign pulses    = {bus.gameOver, bus.pauseKey, bus.collision, bus.startGame};
    assign effective = pending | pulses;

    // Next-state decision. Only evaluated on frame boundaries; the if/else
    // chains encode the priority gameOver > pauseKey > collision > startGame,
    // and any event that a state does not test for is simply dropped.
    always_comb begin
        stateNext = state;
        if (bus.startOfFrame) begin
            case (state)
                IDLE: begin
                    if (effective[0]) stateNext = PLAY;
                end
                PLAY: begin
                    if (effective[3])      stateNext = OVER;
                    else if (effective[2]) stateNext = PAUSE;
                    else if (effective[1]) stateNext = FLASH;
                end
                FLASH: begin
                    if (effective[3])              stateNext = OVER;
                    else if (frameCnt == FLASH_LAST) stateNext = PLAY;
                end
                PAUSE: begin
                    if (effective[3])      stateNext = OVER;
                    else if (effective[2]) stateNext = PLAY;
                end
                OVER: begin
                    if (frameCnt == OVER_LAST) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Frame counter and timer-blink bookkeeping. frameCnt restarts whenever
    // FLASH or OVER is freshly entered (including FLASH -> OVER). The blink
    // counter is frozen while paused so the timer resumes exactly where it
    // stopped; the decision uses the state that was current during the frame
    // that just ended.
    always_comb begin
        frameCntNext = frameCnt;
        blinkCntNext = blinkCnt;
        phaseNext    = phase;
        if (bus.startOfFrame) begin
            if ((stateNext != state) && ((stateNext == FLASH) || (stateNext == OVER))) begin
                frameCntNext = 8'd0;
            end else if ((state == FLASH) || (state == OVER)) begin
                frameCntNext = frameCnt + 8'd1;
            end

            if (state == PAUSE) begin
                blinkCntNext = blinkCnt;
                phaseNext    = phase;
            end else if ((state == IDLE) && (stateNext == PLAY)) begin
                blinkCntNext = 8'd0;
                phaseNext    = 1'b1;
            end else if (!bus.timeLow) begin
                blinkCntNext = 8'd0;
                phaseNext    = 1'b1;
            end else if ((state == PLAY) || (state == FLASH)) begin
                if (blinkCnt == BLINK_LAST) begin
                    blinkCntNext = 8'd0;
                    phaseNext    = ~phase;
                end else begin
                    blinkCntNext = blinkCnt + 8'd1;
                end
            end
        end
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the registered state one cycle after the frame pulse.
    always_comb begin
        layerNext = 3'b000;
        bgNext    = 1'b0;
        rgbNext   = 8'h00;
        case (stateNext)
            PLAY: begin
                layerNext = {phaseNext, 2'b11};
            end
            FLASH: begin
                layerNext = {phaseNext, 2'b11};
                bgNext    = 1'b1;
                rgbNext   = FLASH_RGB;
            end
            PAUSE: begin
                layerNext = 3'b111;
                bgNext    = 1'b1;
                rgbNext   = PAUSE_RGB;
            end
            OVER: begin
                layerNext = 3'b100;
                bgNext    = 1'b1;
                rgbNext   = OVER_RGB;
            end
            default: begin
                layerNext = 3'b000;
            end
        endcase
    end

    // State register plus pending-event latch. Pending bits accumulate during
    // a frame and are wiped at every frame pulse, consumed or not.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            pending <= 4'b0000;
        end else begin
            state <= stateNext;
            if (bus.startOfFrame) begin
                pending <= 4'b0000;
            end else begin
                pending <= pending | pulses;
            end
        end
    end

    // Counters and mux-configuration outputs. The next-value logic holds
    // everything between frame pulses, so these only move at frame boundaries.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frameCnt <= 8'd0;
            blinkCnt <= 8'd0;
            phase    <= 1'b1;
            layerReg <= 3'b000;
            bgReg    <= 1'b0;
            rgbReg   <= 8'h00;
        end else begin
            frameCnt <= frameCntNext;
            blinkCnt <= blinkCntNext;
            phase    <= phaseNext;
            if (bus.startOfFrame) begin
                layerReg <= layerNext;
                bgReg    <= bgNext;
                rgbReg   <= rgbNext;
            end
        end
    end

    assign bus.gameState     = state;
    assign bus.layerEnable   = layerReg;
    assign bus.bgOverride    = bgReg;
    assign bus.bgOverrideRGB = rgbReg;

endmodule
